// File: rtl/req_arbiter_8_pkg.sv
// Shared types, widths and helpers for the 8-way request arbiter.
package arb_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned CODE_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Code c maps to bit (NUM_REQ-1-c); returns an active-low one-hot vector.
   function automatic logic [NUM_REQ-1:0] code_to_onehot_n(input logic [CODE_W-1:0] code);
      logic [NUM_REQ-1:0] vec;
      logic [CODE_W-1:0]  bit_idx;
      vec             = '1;
      bit_idx         = CODE_W'(NUM_REQ - 1) - code;
      vec[bit_idx]    = 1'b0;
      return vec;
   endfunction

endpackage

// File: rtl/req_arbiter_8_pick.sv
// Rotating priority picker: lowest code wins, searched from start_code
// when rr_en is set and from code 0 otherwise.
module rr_prio_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_n,
   input  logic [CODE_W-1:0]  start_code,
   input  logic               rr_en,
   output logic               any,
   output logic [CODE_W-1:0]  code
);

   logic [NUM_REQ-1:0] act;
   logic [NUM_REQ-1:0] rot;
   logic [CODE_W-1:0]  off;
   logic [CODE_W-1:0]  idx;
   logic [CODE_W-1:0]  src;

   // Reorder by code, rotate by the search start, encode, then un-rotate.
   always_comb begin
      act = '0;
      rot = '0;
      idx = '0;
      src = '0;
      off = rr_en ? start_code : '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         act[i] = ~req_n[NUM_REQ-1-i];
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         src    = CODE_W'(i) + off;
         rot[i] = act[src];
      end
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (rot[i]) idx = CODE_W'(i);
      end
      any  = |act;
      code = idx + off;
   end

endmodule

// File: rtl/req_arbiter_8.sv
// 8-way arbiter with active-low requests, fixed or round-robin priority,
// registered grants, a per-grant hold limit and a dead cycle after release.
module req_arbiter_8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned HOLD_W   = 5
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req_n,
   input  logic       rr_en,
   output logic [7:0] gnt_n,
   output logic [2:0] gnt_code,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam bit                HOLD_LIMITED = (MAX_HOLD != 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(MAX_HOLD - 1);

   state_t              state, state_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic [CODE_W-1:0]   last_code, last_nxt;
   logic [NUM_REQ-1:0]  gnt_n_nxt;
   logic [CODE_W-1:0]   code_nxt;
   logic                valid_nxt;
   logic                timeout_nxt;

   logic                pick_any;
   logic [CODE_W-1:0]   pick_code;
   logic [CODE_W-1:0]   start_code;
   logic [CODE_W-1:0]   owner_bit;

   assign start_code = last_code + CODE_W'(1);
   assign owner_bit  = CODE_W'(NUM_REQ - 1) - gnt_code;

   rr_prio_pick u_pick (
      .req_n      (req_n),
      .start_code (start_code),
      .rr_en      (rr_en),
      .any        (pick_any),
      .code       (pick_code)
   );

   // State, hold counter, rotation pointer and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         last_code <= CODE_W'(NUM_REQ - 1);
         gnt_n     <= '1;
         gnt_code  <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         last_code <= last_nxt;
         gnt_n     <= gnt_n_nxt;
         gnt_code  <= code_nxt;
         gnt_valid <= valid_nxt;
         timeout   <= timeout_nxt;
      end
   end

   // Next-state and next-output logic; requests are only arbitrated in IDLE.
   always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      last_nxt    = last_code;
      gnt_n_nxt   = gnt_n;
      code_nxt    = gnt_code;
      valid_nxt   = gnt_valid;
      timeout_nxt = 1'b0;

      case (state)
         IDLE: begin
            gnt_n_nxt = '1;
            valid_nxt = 1'b0;
            if (pick_any) begin
               state_nxt = GRANT;
               gnt_n_nxt = code_to_onehot_n(pick_code);
               code_nxt  = pick_code;
               valid_nxt = 1'b1;
               hold_nxt  = '0;
               last_nxt  = pick_code;
            end
         end
         GRANT: begin
            if (req_n[owner_bit]) begin
               state_nxt = GAP;
               gnt_n_nxt = '1;
               valid_nxt = 1'b0;
            end else if (HOLD_LIMITED && (hold_cnt == HOLD_LAST)) begin
               state_nxt   = GAP;
               gnt_n_nxt   = '1;
               valid_nxt   = 1'b0;
               timeout_nxt = 1'b1;
            end else if (hold_cnt != '1) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         GAP: begin
            state_nxt = IDLE;
            gnt_n_nxt = '1;
            valid_nxt = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
            gnt_n_nxt = '1;
            valid_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Directed bench for req_arbiter_8: inputs change and outputs are checked
// on the falling edge; expected values are hand-computed per scenario.
module tb_req_arbiter_8;

   logic       clk;
   logic       rst;
   logic [7:0] req_n;
   logic       rr_en;
   logic [7:0] gnt_n;
   logic [2:0] gnt_code;
   logic       gnt_valid;
   logic       timeout;

   int n_cmp;
   int n_bad;

   req_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_n     (req_n),
      .rr_en     (rr_en),
      .gnt_n     (gnt_n),
      .gnt_code  (gnt_code),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one full cycle; outputs are settled at the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      req_n = 8'hFF;
      rr_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
            $display("FAIL reset_%0d: got gnt_n=%h code=%0d valid=%b to=%b want FF/0/0/0", i, gnt_n, gnt_code, gnt_valid, timeout);
            n_bad++;
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
            $display("FAIL idle_%0d: got gnt_n=%h code=%0d valid=%b to=%b want FF/0/0/0", i, gnt_n, gnt_code, gnt_valid, timeout);
            n_bad++;
         end
      end
   endtask

   task automatic test_fixed_priority();
      rr_en = 1'b0;
      req_n = 8'b1110_1011;
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'b1110_1111, 3'd3, 1'b1, 1'b0}) begin
         $display("FAIL fixed_grant3: got gnt_n=%b code=%0d valid=%b to=%b want 11101111/3/1/0", gnt_n, gnt_code, gnt_valid, timeout);
         n_bad++;
      end
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'b1110_1111, 3'd3, 1'b1, 1'b0}) begin
         $display("FAIL fixed_no_preempt: got gnt_n=%b code=%0d valid=%b want 11101111/3/1", gnt_n, gnt_code, gnt_valid);
         n_bad++;
      end
      req_n = 8'b1111_1011;
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'hFF, 3'd3, 1'b0, 1'b0}) begin
         $display("FAIL fixed_gap: got gnt_n=%h code=%0d valid=%b to=%b want FF/3/0/0", gnt_n, gnt_code, gnt_valid, timeout);
         n_bad++;
      end
      tick();
      n_cmp++;
      if ({gnt_n, gnt_valid} !== {8'hFF, 1'b0}) begin
         $display("FAIL fixed_idle: got gnt_n=%h valid=%b want FF/0", gnt_n, gnt_valid);
         n_bad++;
      end
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'b1111_1011, 3'd5, 1'b1, 1'b0}) begin
         $display("FAIL fixed_grant5: got gnt_n=%b code=%0d valid=%b to=%b want 11111011/5/1/0", gnt_n, gnt_code, gnt_valid, timeout);
         n_bad++;
      end
      req_n = 8'hFF;
      tick();
      tick();
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_n;
      logic [2:0] e;
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      rr_en = 1'b1;
      req_n = 8'h00;
      for (int k = 0; k < 9; k++) begin
         e            = 3'(k % 8);
         exp_n        = 8'hFF;
         exp_n[3'd7 - e] = 1'b0;
         tick();
         n_cmp++;
         if ({gnt_n, gnt_code, gnt_valid} !== {exp_n, e, 1'b1}) begin
            $display("FAIL rr_grant_%0d: got gnt_n=%b code=%0d valid=%b want %b/%0d/1", k, gnt_n, gnt_code, gnt_valid, exp_n, e);
            n_bad++;
         end
         req_n = ~(~exp_n);
         req_n = 8'h00;
         req_n[3'd7 - e] = 1'b1;
         tick();
         n_cmp++;
         if ({gnt_n, gnt_valid} !== {8'hFF, 1'b0}) begin
            $display("FAIL rr_gap_%0d: got gnt_n=%h valid=%b want FF/0", k, gnt_n, gnt_valid);
            n_bad++;
         end
         req_n = (k == 8) ? 8'hFF : 8'h00;
         tick();
         n_cmp++;
         if ({gnt_n, gnt_valid} !== {8'hFF, 1'b0}) begin
            $display("FAIL rr_idle_%0d: got gnt_n=%h valid=%b want FF/0", k, gnt_n, gnt_valid);
            n_bad++;
         end
      end
   endtask

   task automatic test_timeout();
      rr_en = 1'b1;
      req_n = 8'b1101_1101;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++;
         if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'b1101_1111, 3'd2, 1'b1, 1'b0}) begin
            $display("FAIL hold_cycle_%0d: got gnt_n=%b code=%0d valid=%b to=%b want 11011111/2/1/0", i, gnt_n, gnt_code, gnt_valid, timeout);
            n_bad++;
         end
      end
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'hFF, 3'd2, 1'b0, 1'b1}) begin
         $display("FAIL timeout_pulse: got gnt_n=%h code=%0d valid=%b to=%b want FF/2/0/1", gnt_n, gnt_code, gnt_valid, timeout);
         n_bad++;
      end
      tick();
      n_cmp++;
      if ({gnt_valid, timeout} !== {1'b0, 1'b0}) begin
         $display("FAIL timeout_single: got valid=%b to=%b want 0/0", gnt_valid, timeout);
         n_bad++;
      end
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'b1111_1101, 3'd6, 1'b1, 1'b0}) begin
         $display("FAIL timeout_next_rr: got gnt_n=%b code=%0d valid=%b to=%b want 11111101/6/1/0", gnt_n, gnt_code, gnt_valid, timeout);
         n_bad++;
      end
      req_n = 8'hFF;
      tick();
      tick();
   endtask

   task automatic test_wraparound();
      rr_en = 1'b1;
      req_n = 8'b1111_1110;
      tick();
      n_cmp++;
      if ({gnt_code, gnt_valid} !== {3'd7, 1'b1}) begin
         $display("FAIL wrap_setup7: got code=%0d valid=%b want 7/1", gnt_code, gnt_valid);
         n_bad++;
      end
      req_n = 8'hFF;
      tick();
      tick();
      req_n = 8'b1011_1111;
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid} !== {8'b1011_1111, 3'd1, 1'b1}) begin
         $display("FAIL wrap_code1: got gnt_n=%b code=%0d valid=%b want 10111111/1/1", gnt_n, gnt_code, gnt_valid);
         n_bad++;
      end
      req_n = 8'hFF;
      tick();
      tick();
      req_n = 8'b0101_1111;
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid} !== {8'b1101_1111, 3'd2, 1'b1}) begin
         $display("FAIL wrap_code2: got gnt_n=%b code=%0d valid=%b want 11011111/2/1", gnt_n, gnt_code, gnt_valid);
         n_bad++;
      end
   endtask

   task automatic test_reset_mid_grant();
      rst = 1'b1;
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
         $display("FAIL rst_mid_grant: got gnt_n=%h code=%0d valid=%b to=%b want FF/0/0/0", gnt_n, gnt_code, gnt_valid, timeout);
         n_bad++;
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({gnt_n, gnt_code, gnt_valid, timeout} !== {8'b0111_1111, 3'd0, 1'b1, 1'b0}) begin
         $display("FAIL rst_rearb: got gnt_n=%b code=%0d valid=%b to=%b want 01111111/0/1/0", gnt_n, gnt_code, gnt_valid, timeout);
         n_bad++;
      end
      req_n = 8'hFF;
      tick();
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      req_n = 8'hFF;
      rr_en = 1'b0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_timeout();
      test_wraparound();
      test_reset_mid_grant();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
